// File: rtl/bpsk_ask_demod.sv
// Coherent integrate-and-dump BPSK/ASK demodulator: one decided bit per SYM_LEN strobes.
// Optional saturating bit-error counter enabled by defining DEMOD_ERRCNT_EN.
module bpsk_ask_demod #(
  parameter int          SYM_LEN    = 1024,
  parameter logic [31:0] ASK_THRESH = 32'd524288,
  parameter int          ACC_W      = 25 + $clog2(SYM_LEN)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  mod_sel,
  input  logic        sym_sync,
  input  logic [11:0] sample_in,
  input  logic [11:0] ref_in,
  input  logic        lfsr_ref,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        locked,
  output logic [15:0] err_count
);

  localparam int CNT_W = $clog2(SYM_LEN);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              mod_lat_q, mod_lat_d;
  logic signed [23:0]      p_q, p_d;
  logic                    p_valid_q, p_valid_d;
  logic                    p_last_q, p_last_d;
  logic [1:0]              p_mode_q, p_mode_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    bit_out_q, bit_out_d;
  logic                    bit_valid_q, bit_valid_d;

  logic                    capture;
  logic                    first;
  logic                    last_s1;
  logic [CNT_W-1:0]        cnt_eff;
  logic [1:0]              mode_cur;
  logic signed [23:0]      prod;
  logic [11:0]             mag;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [63:0]      sum_wide;
  logic signed [63:0]      thresh_wide;
  logic                    ask_low;

  assign prod        = $signed(sample_in) * $signed(ref_in);
  // |-2048| wraps to 12'h800, which reads as +2048 once zero-extended
  assign mag         = sample_in[11] ? (~sample_in + 12'd1) : sample_in;
  assign p_ext       = {{(ACC_W-24){p_q[23]}}, p_q};
  assign sum         = acc_q + p_ext;
  assign sum_wide    = {{(64-ACC_W){sum[ACC_W-1]}}, sum};
  assign thresh_wide = {32'd0, ASK_THRESH};
  assign ask_low     = sum_wide < thresh_wide;

  always_comb begin
    state_d = state_q;
    if (sym_sync) state_d = RUN;

    capture  = en && ((state_q == RUN) || sym_sync);
    cnt_eff  = sym_sync ? '0 : cnt_q;
    first    = (cnt_eff == '0);
    last_s1  = (cnt_eff == CNT_W'(SYM_LEN - 1));
    mode_cur = first ? mod_sel : mod_lat_q;

    mod_lat_d = (capture && first) ? mod_sel : mod_lat_q;

    cnt_d = sym_sync ? '0 : cnt_q;
    if (capture) cnt_d = last_s1 ? '0 : cnt_eff + CNT_W'(1);

    p_valid_d = capture;
    p_last_d  = capture && last_s1;
    p_d       = p_q;
    p_mode_d  = p_mode_q;
    if (capture) begin
      p_d      = mode_cur[1] ? prod : $signed({12'd0, mag});
      p_mode_d = mode_cur;
    end

    // A closing product is always decided, even when a resync lands on the same cycle
    acc_d       = acc_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    if (p_valid_q && p_last_q) begin
      acc_d = '0;
      if (!p_mode_q[0]) begin
        bit_valid_d = 1'b1;
        bit_out_d   = p_mode_q[1] ? sum[ACC_W-1] : ask_low;
      end
    end else if (sym_sync) begin
      acc_d = '0;
    end else if (p_valid_q) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mod_lat_q   <= 2'b00;
      p_q         <= '0;
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      p_mode_q    <= 2'b00;
      acc_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mod_lat_q   <= mod_lat_d;
      p_q         <= p_d;
      p_valid_q   <= p_valid_d;
      p_last_q    <= p_last_d;
      p_mode_q    <= p_mode_d;
      acc_q       <= acc_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign locked    = (state_q == RUN);

`ifdef DEMOD_ERRCNT_EN
  logic        lfsr_lat_q, lfsr_lat_d;
  logic        p_lfsr_q, p_lfsr_d;
  logic [15:0] err_q, err_d;

  always_comb begin
    lfsr_lat_d = (capture && first) ? lfsr_ref : lfsr_lat_q;
    p_lfsr_d   = p_lfsr_q;
    if (capture) p_lfsr_d = first ? lfsr_ref : lfsr_lat_q;
    err_d = err_q;
    if (bit_valid_d && (bit_out_d != p_lfsr_q) && (err_q != 16'hFFFF))
      err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_lat_q <= 1'b0;
      p_lfsr_q   <= 1'b0;
      err_q      <= 16'd0;
    end else begin
      lfsr_lat_q <= lfsr_lat_d;
      p_lfsr_q   <= p_lfsr_d;
      err_q      <= err_d;
    end
  end

  assign err_count = err_q;
`else
  logic unused_lfsr;
  assign unused_lfsr = lfsr_ref;
  assign err_count   = 16'd0;
`endif

endmodule
